// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared constants and state encoding for the instruction-fetch
// stage (ifu_fetch) and its holding register (ifu_ibuf).
//   IFU_PC_SIZE    - width of the fetch PC and request address
//   IFU_INSTR_SIZE - width of an instruction word
//   IFU_RESET_PC   - first fetch address after reset
//   ifu_state_e    - fetch FSM encoding (2 bits)
package ifu_fetch_pkg;

  localparam int          IFU_PC_SIZE    = 32;
  localparam int          IFU_INSTR_SIZE = 32;
  localparam logic [31:0] IFU_RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: one-entry holding register for the fetched instruction, its PC
// and its bus-error flag, presented to predecode/decode.
//   clk, rst_n         - clock, async active-low reset
//   load               - capture ld_instr/ld_pc/ld_err
//   flush              - discard held instruction (clears instr/err)
//   ld_instr/pc/err    - values to capture
//   instr, pc, err     - held values
module ifu_ibuf #(
  parameter int                   PC_SIZE    = 32,
  parameter int                   INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic [INSTR_SIZE-1:0] ld_instr,
  input  logic [PC_SIZE-1:0]    ld_pc,
  input  logic                  ld_err,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [PC_SIZE-1:0]    pc,
  output logic                  err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= RESET_PC;
      err   <= 1'b0;
    end else if (load) begin
      instr <= ld_instr;
      pc    <= ld_pc;
      err   <= ld_err;
    end else if (flush) begin
      // pc is left alone: it is meaningless once valid drops
      instr <= '0;
      err   <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: non-pipelined instruction-fetch stage. Owns the fetch PC, issues
// one memory request at a time and holds the returned instruction for
// predecode. Next PC comes from predecode (pd_pc_next) or an EX redirect.
//   clk, rst_n                     - clock, async active-low reset
//   ifu_req_valid/ready/addr       - instruction-memory request channel
//   ifu_rsp_valid/instr/err        - memory response (always accepted)
//   ifu_o_valid/ready/instr/pc/err - instruction handed to predecode
//   pd_pc_next                     - next PC from predecode while ifu_o_valid
//   pc_sel, ex_pc                  - single-cycle redirect strobe and target
module ifu_fetch import ifu_fetch_pkg::*; #(
  parameter int                 PC_SIZE    = IFU_PC_SIZE,
  parameter int                 INSTR_SIZE = IFU_INSTR_SIZE,
  parameter logic [PC_SIZE-1:0] RESET_PC   = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                  ifu_rsp_err,
  output logic                  ifu_o_valid,
  input  logic                  ifu_o_ready,
  output logic [INSTR_SIZE-1:0] ifu_o_instr,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic                  ifu_o_err,
  input  logic [PC_SIZE-1:0]    pd_pc_next,
  input  logic                  pc_sel,
  input  logic [PC_SIZE-1:0]    ex_pc
);

  ifu_state_e         state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               drop_q, drop_d;   // outstanding response is stale
  logic               buf_load, buf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ifu_req_ready) begin
          state_d = S_WAIT;
          // redirect on the handshake cycle: the request is already gone
          if (pc_sel) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (ifu_rsp_valid) begin
          if (drop_q || pc_sel) begin
            // stale response: refetch from the (already redirected) pc
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = S_OUT;
          end
        end else if (pc_sel) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (pc_sel) begin
          buf_flush = 1'b1;
          state_d   = S_REQ;
        end else if (ifu_o_ready) begin
          pc_d    = pd_pc_next;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // redirect wins over every other pc source, in every state
    if (pc_sel) pc_d = ex_pc;
  end

  assign ifu_req_valid = (state_q == S_REQ);
  assign ifu_req_addr  = pc_q;
  assign ifu_o_valid   = (state_q == S_OUT);

  ifu_ibuf #(
    .PC_SIZE    (PC_SIZE),
    .INSTR_SIZE (INSTR_SIZE),
    .RESET_PC   (RESET_PC)
  ) u_ibuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .flush    (buf_flush),
    .ld_instr (ifu_rsp_instr),
    .ld_pc    (pc_q),
    .ld_err   (ifu_rsp_err),
    .instr    (ifu_o_instr),
    .pc       (ifu_o_pc),
    .err      (ifu_o_err)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch. A memory model answers each accepted
// request after a random delay. A reference model tracks the architectural
// fetch PC and, for each request, whether a redirect landed between its
// acceptance and its response; surviving responses are queued as expected
// outputs and a separate monitor compares them as predecode consumes them.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_o_valid, ifu_o_ready, ifu_o_err;
  logic [31:0] ifu_o_instr, ifu_o_pc, pd_pc_next, ex_pc;
  logic        pc_sel;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_instr(ifu_o_instr),
    .ifu_o_pc(ifu_o_pc), .ifu_o_err(ifu_o_err),
    .pd_pc_next(pd_pc_next), .pc_sel(pc_sel), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0, n_out = 0, cyc = 0, last_hs = -1;
  logic [31:0] mpc = RST_PC;            // architectural fetch PC
  // memory model: one outstanding request
  bit          busy = 0, killed = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_pc = '0;
  int          m_dly = 0;
  // knobs (percentages)
  int  p_rdy = 100, p_sel = 0, p_ordy = 100, p_err = 0, p_spur = 0, max_dly = 0;
  bit  pd_rand = 0, fast_chk = 0, force_db = 0;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit pct(int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ifu_req_valid === 1'b1) chk("req_addr", ifu_req_addr, mpc);
      chk("valid_exclusive", {31'b0, ifu_req_valid & ifu_o_valid}, 32'd0);
      if (ifu_o_valid === 1'b1 && (ifu_o_ready || pc_sel)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got pc %h instr %h, expected no output", ifu_o_pc, ifu_o_instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("o_pc", ifu_o_pc, e.pc);
          chk("o_instr", ifu_o_instr, e.instr);
          chk("o_err", {31'b0, ifu_o_err}, {31'b0, e.err});
          if (!pc_sel) n_out++;
        end
      end
      chk("sb_depth_le1", {31'b0, exp_q.size() <= 1}, 32'd1);
    end
  end

  // ---------------- stimulus + memory + reference model ----------------
  task automatic step();
    logic s_hs, s_ov;
    logic [31:0] s_addr, base;
    bit fdb;
    @(negedge clk);
    s_hs = ifu_req_valid && ifu_req_ready;
    s_ov = ifu_o_valid;
    s_addr = ifu_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    // account for what happened at this edge (inputs driven last step)
    if (s_hs) begin
      if (fast_chk && last_hs >= 0) chk("req_spacing", cyc - last_hs, 32'd3);
      last_hs = cyc;
      busy = 1; killed = 0; m_addr = s_addr; m_pc = mpc;
      m_dly = int'($urandom_range(max_dly, 0)); m_err = pct(p_err);
    end
    if (busy && pc_sel) killed = 1;
    if (pc_sel) mpc = ex_pc;
    else if (s_ov && ifu_o_ready) mpc = pd_pc_next;
    // new inputs for the coming cycle
    ifu_req_ready = pct(p_rdy);
    pc_sel        = pct(p_sel);
    ex_pc         = $urandom & 32'hFFFF_FFFC;
    ifu_o_ready   = pct(p_ordy);
    base          = (exp_q.size() > 0) ? exp_q[0].pc : mpc;
    pd_pc_next    = (pd_rand && pct(25)) ? ($urandom & 32'hFFFF_FFFC) : base + 32'd4;
    ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_instr = $urandom;
    if (busy) begin
      if (m_dly == 0) begin
        busy = 0; fdb = force_db; force_db = 0;
        ifu_rsp_valid = 1;
        ifu_rsp_instr = fdb ? 32'hDEAD_BEEF : memf(m_addr);
        ifu_rsp_err   = fdb ? 1'b1 : m_err;
        if (!(killed || pc_sel))
          exp_q.push_back('{pc: m_pc, instr: fdb ? 32'hDEAD_BEEF : memf(m_pc), err: fdb | m_err});
      end else m_dly--;
    end else if (pct(p_spur)) begin
      ifu_rsp_valid = 1;   // protocol-error response, must be ignored
    end
  endtask

  task automatic do_reset(bit late_rsp);
    rst_n = 0;
    #1;
    chk("rst_req_valid", {31'b0, ifu_req_valid}, 32'd0);
    chk("rst_req_addr", ifu_req_addr, RST_PC);
    chk("rst_o_valid", {31'b0, ifu_o_valid}, 32'd0);
    chk("rst_o_instr", ifu_o_instr, 32'd0);
    chk("rst_o_pc", ifu_o_pc, RST_PC);
    chk("rst_o_err", {31'b0, ifu_o_err}, 32'd0);
    busy = 0; killed = 0; exp_q.delete(); mpc = RST_PC; last_hs = -1;
    ifu_req_ready = 0; pc_sel = 0; ex_pc = '0; ifu_o_ready = 0; pd_pc_next = '0;
    ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_instr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    if (late_rsp) begin   // response to the pre-reset request, lands in S_IDLE
      ifu_rsp_valid = 1; ifu_rsp_instr = 32'hBAD0_0BAD; ifu_rsp_err = 1;
    end
    @(posedge clk);
    #1;
    ifu_rsp_valid = 0; ifu_rsp_err = 0;
  endtask

  initial begin
    #2;
    do_reset(0);
    // straight-line fetch: 0x0, 0x4, 0x8 ... one request every 3 cycles
    fast_chk = 1;
    repeat (12) step();
    fast_chk = 0;
    // memory not ready: request must hold its address
    p_rdy = 0;
    repeat (6) step();
    p_rdy = 100;
    repeat (6) step();
    // error response passes through, the next fetch is clean
    force_db = 1;
    repeat (12) step();
    // randomized traffic with redirects, stalls, errors, stray responses
    p_rdy = 60; p_sel = 10; p_ordy = 70; p_err = 15; p_spur = 5; max_dly = 3; pd_rand = 1;
    repeat (3000) step();
    // asynchronous reset while a response is outstanding
    p_sel = 0; p_spur = 0;
    begin
      int n = 0;
      do begin step(); n++; end while (!busy && n < 200);
      chk("reached_wait", {31'b0, busy}, 32'd1);
    end
    #2;
    do_reset(1);
    p_sel = 10; p_spur = 5;
    repeat (1500) step();
    // drain
    p_sel = 0; p_spur = 0; p_ordy = 100; p_rdy = 100;
    repeat (30) step();
    chk("outputs_consumed_min", {31'b0, n_out >= 200}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
